// File: rtl/dff_bank_pkg.sv
// Shared types and defaults for the DFF register bank and its write arbiter.
// The address-width helper keeps a 1-word bank at one address bit.
package dff_bank_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// Write-request, grant/ack and read-port bundle between requesters and the bank.
interface dff_bank_arbiter_if import dff_bank_pkg::*; #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) ();
    localparam int AW = calc_aw(DEPTH);

    logic [N_REQ-1:0]       req;
    logic [N_REQ*AW-1:0]    wr_addr;
    logic [N_REQ*WIDTH-1:0] wr_data;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic                   busy;
    logic [AW-1:0]          rd_addr;
    logic [WIDTH-1:0]       rd_data;

    modport master (
        output req, wr_addr, wr_data, rd_addr,
        input  gnt, ack, busy, rd_data
    );

    modport slave (
        input  req, wr_addr, wr_data, rd_addr,
        output gnt, ack, busy, rd_data
    );
endinterface

// File: rtl/dff_word.sv
// One bank word: edge-triggered register with load enable and async active-low clear.
module dff_word #(
    parameter int WIDTH = 8
) (
    input  logic             c,
    input  logic             rn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_q;

    // storage: cleared on reset, loaded only when enabled
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sequencing one write at a time (IDLE -> CAPTURE -> COMMIT)
// into a DFF register bank, with a combinational read port.
module dff_bank_arbiter import dff_bank_pkg::*; #(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               c,
    input  logic               rn,
    dff_bank_arbiter_if.slave  bus
);
    localparam int AW = calc_aw(DEPTH);
    localparam int PW = calc_aw(N_REQ);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [1:0] S_COMMIT  = ST_COMMIT;
    localparam logic [N_REQ-1:0] L_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    r_win;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_ack;
    logic             r_busy;
    logic [AW-1:0]    r_hold_addr;
    logic [WIDTH-1:0] r_hold_data;

    logic [PW-1:0]    w_win;
    logic [PW-1:0]    w_idx;
    logic             w_found;
    logic [DEPTH-1:0] w_we;
    logic [WIDTH-1:0] w_q [DEPTH];
    logic [WIDTH-1:0] w_rd;

    // round-robin search: walking the offsets downward leaves the nearest set bit from r_ptr
    always_comb begin
        w_win   = '0;
        w_idx   = '0;
        w_found = |bus.req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = PW'((32'(r_ptr) + k) % N_REQ);
            w_win = bus.req[w_idx] ? w_idx : w_win;
        end
    end

    // write sequencer; pointer advances only on a completed commit
    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_win       <= '0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_busy      <= 1'b0;
            r_hold_addr <= '0;
            r_hold_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= '0;
                    if (w_found) begin
                        r_win   <= w_win;
                        r_gnt   <= L_ONE << w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_hold_addr <= bus.wr_addr[32'(r_win) * AW +: AW];
                    r_hold_data <= bus.wr_data[32'(r_win) * WIDTH +: WIDTH];
                    if (!bus.req[r_win]) begin
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_ack   <= L_ONE << r_win;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_win == PW'(N_REQ - 1)) ? '0 : r_win + PW'(1);
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack   <= '0;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // an out-of-range hold_addr matches no word, so the write simply vanishes
    for (genvar i = 0; i < DEPTH; i++) begin : g_bank
        assign w_we[i] = (r_state == S_COMMIT) && (r_hold_addr == AW'(i));
        dff_word #(.WIDTH(WIDTH)) u_word (
            .c      (c),
            .rn     (rn),
            .i_load (w_we[i]),
            .i_d    (r_hold_data),
            .o_q    (w_q[i])
        );
    end

    // read mux as an AND-OR over word selects; unmapped addresses read zero
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rd = w_rd | (w_q[i] & {WIDTH{bus.rd_addr == AW'(i)}});
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.ack     = r_ack;
    assign bus.busy    = r_busy;
    assign bus.rd_data = w_rd;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed plus randomized bench for dff_bank_arbiter against a transaction-level model.
module tb_dff_bank_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int D  = 4;
    localparam int AW = 2;

    logic c  = 1'b0;
    logic rn = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [W-1:0]  m_bank [D];
    logic [AW-1:0] m_addr [N];
    logic [W-1:0]  m_data [N];
    int            m_ptr;
    logic [N-1:0]  pend;
    logic [N-1:0]  mask;

    dff_bank_arbiter_if #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) bus ();
    dff_bank_arbiter #(.N_REQ(N), .WIDTH(W), .DEPTH(D)) dut (.c(c), .rn(rn), .bus(bus));

    always #5 c = ~c;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    function automatic int exp_win(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            if (m[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [W-1:0] d);
        m_addr[i] = a;
        m_data[i] = d;
        bus.wr_addr[i*AW +: AW] = a;
        bus.wr_data[i*W +: W]   = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < D; i++) m_bank[i] = '0;
        m_ptr = 0;
    endtask

    // one full write: grant after the IDLE edge, ack and new data after the COMMIT edge
    task automatic transact(input logic [N-1:0] m, input bit reraise);
        int w;
        w = exp_win(m);
        bus.req     = m;
        bus.rd_addr = m_addr[w];
        tick();
        if (reraise) bus.req = bus.req | pend;
        chk("gnt_capture", 32'(bus.gnt), 32'(1) << w);
        chk("busy_capture", 32'(bus.busy), 32'd1);
        chk("ack_capture", 32'(bus.ack), 32'd0);
        chk("rd_old_capture", 32'(bus.rd_data), 32'(m_bank[m_addr[w]]));
        tick();
        chk("gnt_commit", 32'(bus.gnt), 32'(1) << w);
        chk("rd_old_commit", 32'(bus.rd_data), 32'(m_bank[m_addr[w]]));
        tick();
        m_bank[m_addr[w]] = m_data[w];
        m_ptr = (w + 1) % N;
        chk("ack_pulse", 32'(bus.ack), 32'(1) << w);
        chk("gnt_idle", 32'(bus.gnt), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("rd_new", 32'(bus.rd_data), 32'(m_bank[m_addr[w]]));
        pend    = N'(1) << w;
        bus.req = bus.req & ~pend;
    endtask

    // winner drops its request during CAPTURE; nothing may be written or acked
    task automatic abort(input logic [N-1:0] m);
        int w;
        w = exp_win(m);
        bus.req     = m;
        bus.rd_addr = m_addr[w];
        tick();
        chk("abort_gnt", 32'(bus.gnt), 32'(1) << w);
        bus.req = '0;
        tick();
        chk("abort_gnt_clr", 32'(bus.gnt), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_ack", 32'(bus.ack), 32'd0);
        tick();
        chk("abort_no_ack", 32'(bus.ack), 32'd0);
        chk("abort_rd", 32'(bus.rd_data), 32'(m_bank[m_addr[w]]));
    endtask

    task automatic check_bank(input string tag);
        for (int a = 0; a < D; a++) begin
            bus.rd_addr = AW'(a);
            #1;
            chk(tag, 32'(bus.rd_data), 32'(m_bank[a]));
        end
    endtask

    initial begin
        bus.req = '0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        pend = '0;
        model_reset();
        for (int i = 0; i < N; i++) set_src(i, '0, '0);
        #12;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        check_bank("rst_bank");
        @(negedge c); rn = 1'b1;
        tick();

        set_src(0, 2'd2, 8'hA5);
        transact(4'b0001, 1'b0);
        bus.req = '0;
        bus.rd_addr = 2'd2; #1;
        chk("a5_readback", 32'(bus.rd_data), 32'h0000_00A5);

        set_src(1, 2'd3, 8'h5A);
        bus.req = 4'b0010;
        tick();
        chk("pre_reset_gnt", 32'(bus.gnt), 32'h0000_0002);
        rn = 1'b0;
        #2;
        model_reset();
        chk("midrst_gnt", 32'(bus.gnt), 32'd0);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        check_bank("midrst_bank");
        bus.req = '0;
        @(negedge c); rn = 1'b1;
        tick();

        pend = '0;
        transact(4'b1111, 1'b0);
        for (int i = 0; i < N; i++) transact(bus.req, 1'b1);
        bus.req = '0;

        set_src(3, 2'd1, 8'h3C);
        transact(4'b1000, 1'b0);
        bus.req = '0;

        set_src(2, 2'd0, 8'h77);
        abort(4'b0100);
        check_bank("abort_bank");
        set_src(1, 2'd3, 8'hC3);
        transact(4'b0110, 1'b0);
        bus.req = '0;

        set_src(3, 2'd2, 8'h11);
        set_src(0, 2'd3, 8'h22);
        transact(4'b1000, 1'b0);
        transact(4'b1001, 1'b0);
        bus.req = '0;

        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < N; i++)
                set_src(i, AW'($urandom_range(0, D - 1)), W'($urandom_range(0, 255)));
            mask = N'($urandom_range(1, 15));
            if ($urandom_range(0, 3) == 0) abort(mask);
            else transact(mask, 1'b0);
            bus.req = '0;
        end
        check_bank("final_bank");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
